// File: rtl/io_handshake_ctrl.sv
// I/O instruction sequencer: stalls the core on in/out, waits for a debounced
// operator confirm press, latches switches or the out operand, then releases for one cycle.
module io_handshake_ctrl #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 18,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic              out_req,
  input  logic              confirm_btn,
  input  logic [SW_W-1:0]   switches,
  input  logic [DATA_W-1:0] out_data,
  output logic              io_wait,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] display,
  output logic              display_valid,
  output logic              io_done
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_PRESS = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;

  if (SW_W > DATA_W) begin : g_bad_sw_w
    $error("io_handshake_ctrl: SW_W must not exceed DATA_W");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("io_handshake_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end

  logic              sync_meta_q, sync_meta_d;
  logic              sync_q, sync_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q, db_prev_d;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]        state_q, state_d;
  logic              op_is_in_q, op_is_in_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              display_valid_q, display_valid_d;

  logic              any_req;
  logic              press;

  assign any_req = in_req | out_req;

  // Button front end: two-flop synchronizer feeding a stability counter.
  always_comb begin
    sync_meta_d = confirm_btn;
    sync_d      = sync_meta_q;
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    db_prev_d   = db_level_q;
    if (sync_q != db_level_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_level_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
  end

  // Rising edge of the debounced level only, so a held button confirms once.
  assign press = db_level_q & ~db_prev_q;

  // Handshake FSM and data latches.
  always_comb begin
    state_d         = state_q;
    op_is_in_d      = op_is_in_q;
    in_data_d       = in_data_q;
    display_d       = display_q;
    display_valid_d = display_valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_is_in_d = in_req;
          state_d    = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (press) begin
          state_d = DONE;
          if (op_is_in_q) begin
            in_data_d = DATA_W'(switches);
          end else begin
            display_d       = out_data;
            display_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta_q     <= 1'b0;
      sync_q          <= 1'b0;
      db_level_q      <= 1'b0;
      db_prev_q       <= 1'b0;
      db_cnt_q        <= '0;
      state_q         <= IDLE;
      op_is_in_q      <= 1'b0;
      in_data_q       <= '0;
      display_q       <= '0;
      display_valid_q <= 1'b0;
    end else begin
      sync_meta_q     <= sync_meta_d;
      sync_q          <= sync_d;
      db_level_q      <= db_level_d;
      db_prev_q       <= db_prev_d;
      db_cnt_q        <= db_cnt_d;
      state_q         <= state_d;
      op_is_in_q      <= op_is_in_d;
      in_data_q       <= in_data_d;
      display_q       <= display_d;
      display_valid_q <= display_valid_d;
    end
  end

  // Stall is combinational so the core holds in the instruction's first cycle.
  assign io_wait       = ((state_q == IDLE) & any_req) | (state_q == WAIT_PRESS);
  assign io_done       = (state_q == DONE);
  assign in_data       = in_data_q;
  assign display       = display_q;
  assign display_valid = display_valid_q;

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Directed bench for io_handshake_ctrl with a 4-cycle debounce window.
module tb_io_handshake_ctrl;

  localparam int DATA_W = 32;
  localparam int SW_W   = 18;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_req = 1'b0;
  logic              out_req = 1'b0;
  logic              confirm_btn = 1'b0;
  logic [SW_W-1:0]   switches = '0;
  logic [DATA_W-1:0] out_data = '0;
  logic              io_wait;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] display;
  logic              display_valid;
  logic              io_done;

  int vectors = 0;
  int miscompares = 0;

  io_handshake_ctrl #(
    .DATA_W(DATA_W),
    .SW_W(SW_W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_req(in_req),
    .out_req(out_req),
    .confirm_btn(confirm_btn),
    .switches(switches),
    .out_data(out_data),
    .io_wait(io_wait),
    .in_data(in_data),
    .display(display),
    .display_valid(display_valid),
    .io_done(io_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    in_req = 1'b1;
    #1 reset = 1'b1;
    step();
    step();
    vectors++;
    if ({in_data, display, display_valid, io_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got in=%h disp=%h dv=%b done=%b, expected all zero",
               in_data, display, display_valid, io_done);
    end
    vectors++;
    if (io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_io_wait: got %b expected 1", io_wait);
    end
    reset = 1'b0;
    step();
    in_req = 1'b0;
    #1;
    vectors++;
    if (io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_then_wait_press: io_wait got %b expected 1", io_wait);
    end
    step();
    vectors++;
    if (io_wait !== 1'b0 || io_done !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_to_idle: io_wait=%b io_done=%b expected 0 0", io_wait, io_done);
    end
  endtask

  task automatic test_in_path();
    switches = 18'h2A5C3;
    in_req   = 1'b1;
    #1;
    vectors++;
    if (io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL in_first_cycle_wait: got %b expected 1", io_wait);
    end
    confirm_btn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      vectors++;
      if (io_wait !== 1'b1 || io_done !== 1'b0) begin
        miscompares++;
        $display("FAIL in_stall edge %0d: io_wait=%b io_done=%b expected 1 0", k, io_wait, io_done);
      end
    end
    step();
    vectors++;
    if (io_done !== 1'b1 || io_wait !== 1'b0) begin
      miscompares++;
      $display("FAIL in_done edge 7: io_done=%b io_wait=%b expected 1 0", io_done, io_wait);
    end
    vectors++;
    if (in_data !== 32'h0002A5C3) begin
      miscompares++;
      $display("FAIL in_data_latch: got %h expected 0002a5c3", in_data);
    end
    step();
    vectors++;
    if (io_done !== 1'b0 || io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL in_back_idle: io_done=%b io_wait=%b expected 0 1", io_done, io_wait);
    end
    vectors++;
    if (display !== 32'h0 || display_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL in_display_untouched: display=%h dv=%b expected 0 0", display, display_valid);
    end
    in_req = 1'b0;
    confirm_btn = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_out_path();
    int n;
    n = 0;
    switches    = 18'h3FFFF;
    out_data    = 32'hDEADBEEF;
    out_req     = 1'b1;
    confirm_btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (io_done === 1'b1) n++;
    end
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL out_done_count: got %0d pulses expected 1", n);
    end
    vectors++;
    if (display !== 32'hDEADBEEF || display_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL out_display: display=%h dv=%b expected deadbeef 1", display, display_valid);
    end
    vectors++;
    if (in_data !== 32'h0002A5C3) begin
      miscompares++;
      $display("FAIL out_in_data_hold: got %h expected 0002a5c3", in_data);
    end
    out_req = 1'b0;
    confirm_btn = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_bounce();
    int n;
    n = 0;
    in_req   = 1'b1;
    switches = 18'h00155;
    for (int r = 0; r < 4; r++) begin
      confirm_btn = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        if (io_done === 1'b1) n++;
      end
      confirm_btn = 1'b0;
      step();
      if (io_done === 1'b1) n++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (io_done === 1'b1) n++;
    end
    vectors++;
    if (n !== 0 || io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_reject: done pulses=%0d io_wait=%b expected 0 1", n, io_wait);
    end
    n = 0;
    confirm_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (io_done === 1'b1) n++;
    end
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL bounce_stable_press: got %0d pulses expected 1", n);
    end
    vectors++;
    if (in_data !== 32'h00000155) begin
      miscompares++;
      $display("FAIL bounce_in_data: got %h expected 00000155", in_data);
    end
    in_req = 1'b0;
    confirm_btn = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_back_to_back();
    int n;
    int stall_bad;
    in_req      = 1'b1;
    switches    = 18'h11111;
    confirm_btn = 1'b1;
    idle_cycles(7);
    vectors++;
    if (io_done !== 1'b1 || in_data !== 32'h00011111) begin
      miscompares++;
      $display("FAIL b2b_first: io_done=%b in_data=%h expected 1 00011111", io_done, in_data);
    end
    switches  = 18'h22222;
    n         = 0;
    stall_bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (io_done === 1'b1) n++;
      if (io_wait !== 1'b1) stall_bad++;
    end
    vectors++;
    if (n !== 0 || stall_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_held_stall: done pulses=%0d unstalled cycles=%0d expected 0 0", n, stall_bad);
    end
    switches    = 18'h2BEEF;
    confirm_btn = 1'b0;
    idle_cycles(6);
    confirm_btn = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (io_done === 1'b1) n++;
    end
    step();
    vectors++;
    if (n !== 0 || io_done !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_done: early pulses=%0d io_done=%b expected 0 1", n, io_done);
    end
    vectors++;
    if (in_data !== 32'h0002BEEF) begin
      miscompares++;
      $display("FAIL b2b_fresh_switches: got %h expected 0002beef", in_data);
    end
    in_req = 1'b0;
    confirm_btn = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_priority();
    in_req      = 1'b1;
    out_req     = 1'b1;
    switches    = 18'h00ABC;
    out_data    = 32'h12345678;
    confirm_btn = 1'b1;
    idle_cycles(7);
    vectors++;
    if (io_done !== 1'b1 || in_data !== 32'h00000ABC || display !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL in_priority: done=%b in_data=%h display=%h expected 1 00000abc deadbeef",
               io_done, in_data, display);
    end
    in_req = 1'b0;
    out_req = 1'b0;
    confirm_btn = 1'b0;
    idle_cycles(8);
  endtask

  task automatic test_reset_mid();
    int n;
    int wait_bad;
    in_req      = 1'b1;
    switches    = 18'h3ABCD;
    confirm_btn = 1'b1;
    idle_cycles(5);
    vectors++;
    if (io_wait !== 1'b1 || io_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_pre_reset: io_wait=%b io_done=%b expected 1 0", io_wait, io_done);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_data, display, display_valid, io_done} !== '0 || io_wait !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_regs: in=%h disp=%h dv=%b done=%b wait=%b expected 0 0 0 0 1",
               in_data, display, display_valid, io_done, io_wait);
    end
    in_req = 1'b0;
    #1;
    vectors++;
    if (io_wait !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: io_wait got %b expected 0", io_wait);
    end
    step();
    reset = 1'b0;
    n = 0;
    wait_bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (io_done === 1'b1) n++;
      if (io_wait !== 1'b0) wait_bad++;
    end
    vectors++;
    if (n !== 0 || wait_bad !== 0 || in_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_after_reset: done pulses=%0d stalled cycles=%0d in_data=%h expected 0 0 0",
               n, wait_bad, in_data);
    end
    confirm_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_in_path();
    test_out_path();
    test_bounce();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_handshake_ctrl.md
# io_handshake_ctrl

Sequencer for the processor's `in` and `out` I/O instructions. While the control decoder's input or output request is asserted, it holds the core through the decoder's `flag` input. It waits for a debounced operator confirm-button press, then latches the switch word (for `in`) or the register operand (for `out`). It then releases the core for exactly one cycle so the instruction commits.

## Interface
- `DATA_W`, 32: datapath word width.
- `SW_W`, 18: switch bank width; must be ≤ `DATA_W`.
- `DEBOUNCE_CYCLES`, 50000: cycles the synchronized button must stay stable before the debounced level changes; must be ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_req`  in  1  decoder `MO`; an `in` instruction is executing.
- `out_req`  in  1  decoder `out`; an `out` instruction is executing.
- `confirm_btn`  in  1  raw asynchronous push-button, active-high.
- `switches`  in  `SW_W`  raw switch bank.
- `out_data`  in  `DATA_W`  register-file operand of the `out` instruction.
- `io_wait`  out  1  drives the decoder `flag` input; 1 = hold the core.
- `in_data`  out  `DATA_W`  latched switch word, zero-extended; feeds the register write mux.
- `display`  out  `DATA_W`  latched `out` value for the display driver.
- `display_valid`  out  1  sticky; set at the first completed `out`.
- `io_done`  out  1  one-cycle pulse; the I/O instruction commits this cycle.

## Operation
- Button front end:
  - 2-flop synchronizer, giving `sync`.
  - Debouncer holds level `btn_db` and a counter of width clog2(`DEBOUNCE_CYCLES`).
  - Counter clears whenever `sync == btn_db`; otherwise it increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and there is still a mismatch: `btn_db <= sync` and the counter clears.
  - `btn_db_q` is `btn_db` delayed one cycle.
  - `press = btn_db & ~btn_db_q`. Press is edge-based only, so a held button never confirms a second instruction.
- State register, 2 bits, with states IDLE, WAIT_PRESS and DONE:
  - IDLE: if `in_req | out_req`, capture `op_is_in = in_req` (`in_req` has priority if both are set) and go to WAIT_PRESS. Otherwise stay in IDLE.
  - WAIT_PRESS:
    - If `!(in_req | out_req)` (request withdrawn): go to IDLE and latch nothing.
    - Else if `press`: latch data and go to DONE. For `op_is_in`, `in_data <= {zero, switches}`, sampled at that edge. Otherwise `display <= out_data` and `display_valid <= 1`.
    - Else stay in WAIT_PRESS.
  - DONE: go to IDLE unconditionally.
- `io_wait` is combinational so the core stalls in the instruction's first cycle: `io_wait = (IDLE & (in_req | out_req)) | WAIT_PRESS`.
- `io_done = (state == DONE)`, registered state decode. During DONE `io_wait = 0`, so the decoder releases `halt`, the `in` write commits `in_data`, and the PC advances.
- Back-to-back I/O instructions: the following IDLE cycle sees the new request and re-enters WAIT_PRESS. A new button press is required.
- `in_data` and `display` hold their value between operations.

## Timing
- Reset (async assert, synchronous release is handled upstream) sets:
  - state to IDLE;
  - `sync`, `btn_db`, `btn_db_q` and the counter to 0;
  - `in_data`, `display`, `display_valid` and `io_done` to 0.
  - `io_wait` is then 0 unless a request is present.
- Press latency, with the raw button rising before edge 1 and held:
  - `btn_db` rises at edge `DEBOUNCE_CYCLES+2`;
  - `press` is high in the following cycle;
  - the state enters DONE at edge `DEBOUNCE_CYCLES+3`;
  - `io_done` is high for exactly that one cycle.
- Glitch rejection: a raw pulse, or any bounce shorter than `DEBOUNCE_CYCLES` cycles after synchronization, never changes `btn_db`.
- Release must likewise be stable for `DEBOUNCE_CYCLES` before `btn_db` falls. Until it falls, no new `press` can occur.
- Button already held when a request arrives: no confirmation occurs until a release is debounced and then a new press is debounced.
- Reset during WAIT_PRESS or DONE: immediate return to IDLE, with no latch and no `io_done`.
- The I/O stall per instruction is at least `DEBOUNCE_CYCLES+3` cycles.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4.
- Reset with `in_req=1`:
  - during reset, all registered outputs = 0 and `io_wait = 1` combinationally;
  - after release, the state is WAIT_PRESS.
- `in` path:
  - stimulus: `in_req=1`, `switches=18'h2A5C3`, clean press held 20 cycles;
  - `io_wait` stays 1 until edge 7 after the press;
  - then `io_wait=0` and `io_done=1` for one cycle, with `in_data = 32'h0002A5C3`;
  - back in IDLE, `display` is unchanged.
- `out` path:
  - stimulus: `out_req=1`, `out_data=32'hDEADBEEF`, press;
  - required: `display = 32'hDEADBEEF`, `display_valid = 1`, single `io_done`, `in_data` unchanged.
- Bounce:
  - stimulus: a press of 3-cycle high pulses separated by 1-cycle lows;
  - required: no `io_done`; a final stable 10-cycle high gives exactly one `io_done`.
- Held button across back-to-back `in` instructions:
  - stimulus: the button is kept high after the first completion;
  - required: the second request keeps `io_wait=1` indefinitely;
  - releasing for ≥6 cycles, then pressing again, completes the second request with freshly sampled switches.
- Reset asserted mid-WAIT_PRESS, just before `btn_db` rises: no `io_done`, `in_data` stays 0, the state is IDLE.
